// File: rtl/vga_frame_ctrl.sv
// 640x480@60 timing generator with per-frame board snapshot, sync/pixel alignment
// pipeline and frame/blink strobes. Geometry is parameterised; defaults are VGA 640x480.
module vga_frame_ctrl #(
  parameter int PIX_DIV      = 4,
  parameter int SYNC_DLY     = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [323:0] board_in,
  input  logic [80:0]  board_blank_in,
  input  logic [11:0]  pixel_in,
  output logic [9:0]   h_cnt,
  output logic [9:0]   v_cnt,
  output logic         pix_tick,
  output logic [323:0] board,
  output logic [80:0]  board_blank,
  output logic         frame_start,
  output logic         blink,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         hsync,
  output logic         vsync
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(PIX_DIV - 2);

  localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [5:0] BLINK_MAX = 6'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_tick;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [323:0]     r_board;
  logic [80:0]      r_board_blank;
  logic             r_frame_start;
  logic             r_blink;
  logic [5:0]       r_frame_cnt;
  logic [11:0]      r_rgb;
  // Each stage holds {hs_n, vs_n, valid}
  logic [SYNC_DLY:0][2:0] r_stage;

  logic       w_div_pre;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_valid;
  logic       w_hs_n;
  logic       w_vs_n;
  logic [2:0] w_timing;
  logic [2:0] w_last_in;

  assign w_div_pre = (r_div_cnt == DIV_PRE);
  assign w_h_last  = (r_h_cnt == H_MAX);
  assign w_v_last  = (r_v_cnt == V_MAX);
  assign w_valid   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs_n    = !((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END));
  assign w_vs_n    = !((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END));
  assign w_timing  = {w_hs_n, w_vs_n, w_valid};

  // RGB is gated by the timing entering the last stage so it lands on the pins
  // in the same tick as the matching hsync/vsync.
  generate
    if (SYNC_DLY == 0) begin : g_nodly
      assign w_last_in = w_timing;
    end else begin : g_dly
      assign w_last_in = r_stage[SYNC_DLY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div_cnt  <= (r_div_cnt == DIV_MAX) ? '0 : r_div_cnt + DIV_W'(1);
      r_pix_tick <= w_div_pre;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_pix_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= SYNC_DLY; k++) begin
        r_stage[k] <= 3'b110;
      end
      r_rgb <= '0;
    end else if (r_pix_tick) begin
      r_stage[0] <= w_timing;
      for (int k = 1; k <= SYNC_DLY; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
      r_rgb <= w_last_in[0] ? pixel_in : 12'h000;
    end
  end

  // Snapshot at the first tick of vblank so visible lines always see a stable board
  always_ff @(posedge clk) begin
    if (rst) begin
      r_board       <= '0;
      r_board_blank <= '0;
    end else if (r_pix_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS)) begin
      r_board       <= board_in;
      r_board_blank <= board_blank_in;
    end
  end

  // Frame strobe is raised alongside the pix_tick that wraps the counters to (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_div_pre && w_h_last && w_v_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_frame_start) begin
      if (r_frame_cnt == BLINK_MAX) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;
  assign pix_tick    = r_pix_tick;
  assign board       = r_board;
  assign board_blank = r_board_blank;
  assign frame_start = r_frame_start;
  assign blink       = r_blink;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign hsync       = r_stage[SYNC_DLY][2];
  assign vsync       = r_stage[SYNC_DLY][1];

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl: full VGA geometry for line-level checks, plus a scaled-down
// geometry instance so frame, snapshot and blink behaviour fit in a short run.
module tb_vga_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: default 640x480 timing, PIX_DIV=4, SYNC_DLY=1
  logic         rst_a;
  logic [323:0] board_in_a, board_a;
  logic [80:0]  blank_in_a, blank_a;
  logic [11:0]  pixel_in_a;
  logic [9:0]   h_cnt_a, v_cnt_a;
  logic         tick_a, fs_a, blink_a, hsync_a, vsync_a;
  logic [3:0]   r_a, g_a, b_a;
  logic [11:0]  rgb_a;
  assign rgb_a = {r_a, g_a, b_a};

  vga_frame_ctrl #(.PIX_DIV(4), .SYNC_DLY(1), .BLINK_FRAMES(30)) dut_a (
    .clk(clk), .rst(rst_a), .board_in(board_in_a), .board_blank_in(blank_in_a),
    .pixel_in(pixel_in_a), .h_cnt(h_cnt_a), .v_cnt(v_cnt_a), .pix_tick(tick_a),
    .board(board_a), .board_blank(blank_a), .frame_start(fs_a), .blink(blink_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hsync(hsync_a), .vsync(vsync_a)
  );

  // Instance B: 16x10 total (8x6 visible, hsync h=10..12, vsync v=7..8), PIX_DIV=2
  logic         rst_b;
  logic [323:0] board_in_b, board_b;
  logic [80:0]  blank_in_b, blank_b;
  logic [11:0]  pixel_in_b;
  logic [9:0]   h_cnt_b, v_cnt_b;
  logic         tick_b, fs_b, blink_b, hsync_b, vsync_b;
  logic [3:0]   r_b, g_b, b_b;
  logic [11:0]  rgb_b;
  assign rgb_b = {r_b, g_b, b_b};

  vga_frame_ctrl #(
    .PIX_DIV(2), .SYNC_DLY(1), .BLINK_FRAMES(2),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .board_in(board_in_b), .board_blank_in(blank_in_b),
    .pixel_in(pixel_in_b), .h_cnt(h_cnt_b), .v_cnt(v_cnt_b), .pix_tick(tick_b),
    .board(board_b), .board_blank(blank_b), .frame_start(fs_b), .blink(blink_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync(hsync_b), .vsync(vsync_b)
  );

  typedef struct {
    int          adv;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        tick;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [323:0] act, input logic [323:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic wait_hv_b(input logic [9:0] h, input logic [9:0] v, input string name);
    int n;
    n = 0;
    while (!(h_cnt_b == h && v_cnt_b == v) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) timeout(name);
  endtask

  initial begin
    logic [323:0] x1, x2;
    logic [80:0]  y1, y2;
    int low, falls, fs_seen, vs_low, rgb_nz, rgb_ok, fc, n;
    logic prev, pend, exp_blink;
    logic [9:0] h_first;

    x1 = {27{12'h123}};
    x2 = {27{12'h9A8}};
    y1 = {27{3'b101}};
    y2 = {27{3'b011}};

    //            adv   h        v       tick  hs    vs    rgb
    vecs[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[1]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 12'h000};
    vecs[2]  = '{1,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[3]  = '{4,    10'd2,   10'd0, 1'b0, 1'b1, 1'b1, 12'hFFF};
    vecs[4]  = '{2556, 10'd641, 10'd0, 1'b0, 1'b1, 1'b1, 12'hFFF};
    vecs[5]  = '{4,    10'd642, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[6]  = '{60,   10'd657, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[7]  = '{4,    10'd658, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000};
    vecs[8]  = '{380,  10'd753, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000};
    vecs[9]  = '{4,    10'd754, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[10] = '{184,  10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[11] = '{8,    10'd2,   10'd1, 1'b0, 1'b1, 1'b1, 12'hFFF};

    rst_a = 1'b1; rst_b = 1'b1;
    board_in_a = '0; blank_in_a = '0; pixel_in_a = 12'hFFF;
    board_in_b = '0; blank_in_b = '0; pixel_in_b = 12'h5A3;

    // Reset, first tick and one line of timing on the full-size instance
    repeat (5) step();
    rst_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      repeat (vecs[i].adv) step();
      check($sformatf("v%0d_h", i), h_cnt_a, vecs[i].h);
      check($sformatf("v%0d_v", i), v_cnt_a, vecs[i].v);
      check($sformatf("v%0d_tick", i), tick_a, vecs[i].tick);
      check($sformatf("v%0d_hsync", i), hsync_a, vecs[i].hs);
      check($sformatf("v%0d_vsync", i), vsync_a, vecs[i].vs);
      check($sformatf("v%0d_rgb", i), rgb_a, vecs[i].rgb);
      $display("vec %0d: h=%0d v=%0d tick=%0b hs=%0b vs=%0b rgb=%03h",
               i, h_cnt_a, v_cnt_a, tick_a, hsync_a, vsync_a, rgb_a);
    end
    check("a_frame_start_idle", fs_a, 1'b0);

    // Whole line 1: hsync low for one contiguous 96-tick run starting at h=656 (+2 ticks)
    low = 0; falls = 0; prev = 1'b1; h_first = '0;
    for (int i = 0; i < 3200; i++) begin
      step();
      if (!hsync_a) begin
        if (prev) begin
          falls++;
          h_first = h_cnt_a;
        end
        low++;
      end
      prev = hsync_a;
    end
    check("hs_low_clks", low, 384);
    check("hs_falls", falls, 1);
    check("hs_first_h", h_first, 10'd658);
    check("line_end_h", h_cnt_a, 10'd2);
    check("line_end_v", v_cnt_a, 10'd2);
    $display("line: hsync low %0d clks, fall at h=%0d", low, h_first);

    // Mid-line reset at h=300 restarts timing at (0,0)
    n = 0;
    while (h_cnt_a != 10'd300 && n < 4000) begin step(); n++; end
    if (n >= 4000) timeout("a_wait_h300");
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("a_rst_h", h_cnt_a, 10'd0);
    check("a_rst_v", v_cnt_a, 10'd0);
    check("a_rst_rgb", rgb_a, 12'h000);
    check("a_rst_hsync", hsync_a, 1'b1);
    repeat (3) step();
    check("a_rst_tick", tick_a, 1'b1);
    step();
    check("a_rst_h_next", h_cnt_a, 10'd1);
    $display("a mid-line reset: h=%0d v=%0d", h_cnt_a, v_cnt_a);

    // Frame-level behaviour on the scaled instance (frame = 160 ticks = 320 clks)
    rst_b = 1'b0;
    check("b_rst_fs", fs_b, 1'b0);
    check("b_rst_blink", blink_b, 1'b0);
    check("b_rst_board", board_b, 324'd0);
    fs_seen = 0; vs_low = 0; rgb_nz = 0; rgb_ok = 0; fc = 0;
    pend = 1'b0; exp_blink = 1'b0;
    for (int k = 1; k <= 1280; k++) begin
      step();
      if (pend) begin
        check($sformatf("blink_after_fs%0d", fs_seen), blink_b, exp_blink);
        pend = 1'b0;
      end
      if (fs_b) begin
        fs_seen++;
        check($sformatf("fs%0d_clk", fs_seen), k, 319 + 320 * (fs_seen - 1));
        if (fc == 1) begin
          fc = 0;
          exp_blink = ~exp_blink;
        end else begin
          fc++;
        end
        pend = 1'b1;
        $display("frame_start %0d at clk %0d", fs_seen, k);
      end
      if (!vsync_b) vs_low++;
      if (rgb_b != 12'h000) rgb_nz++;
      if (rgb_b == 12'h5A3) rgb_ok++;
    end
    check("fs_count", fs_seen, 4);
    check("vs_low_clks", vs_low, 256);
    check("rgb_nz_clks", rgb_nz, 384);
    check("rgb_val_clks", rgb_ok, 384);

    // Snapshot: changes during visible lines wait for vblank; changes in vblank wait a frame
    wait_hv_b(10'd0, 10'd2, "snap_v2");
    board_in_b = x1; blank_in_b = y1;
    wait_hv_b(10'd0, 10'd6, "snap_v6a");
    check("snap_hold_board", board_b, 324'd0);
    check("snap_hold_blank", blank_b, 81'd0);
    repeat (2) step();
    check("snap_take_board", board_b, x1);
    check("snap_take_blank", blank_b, y1);
    $display("snapshot 1 taken at h=%0d v=%0d", h_cnt_b, v_cnt_b);
    wait_hv_b(10'd0, 10'd8, "snap_v8");
    board_in_b = x2; blank_in_b = y2;
    wait_hv_b(10'd0, 10'd3, "snap_v3");
    check("snap_vblank_ignored", board_b, x1);
    wait_hv_b(10'd0, 10'd6, "snap_v6b");
    check("snap_hold2_board", board_b, x1);
    repeat (2) step();
    check("snap_take2_board", board_b, x2);
    check("snap_take2_blank", blank_b, y2);
    $display("snapshot 2 taken at h=%0d v=%0d", h_cnt_b, v_cnt_b);

    // Reset with blink high mid-line clears blink and position
    n = 0;
    while (blink_b != 1'b1 && n < 2000) begin step(); n++; end
    if (n >= 2000) timeout("b_wait_blink");
    wait_hv_b(10'd3, 10'd4, "b_wait_mid");
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("b_rst_blink2", blink_b, 1'b0);
    check("b_rst_h2", h_cnt_b, 10'd0);
    check("b_rst_v2", v_cnt_b, 10'd0);
    check("b_rst_board2", board_b, 324'd0);
    $display("b mid-line reset: blink=%0b h=%0d v=%0d", blink_b, h_cnt_b, v_cnt_b);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
